serial_word_comparator: RTL and testbench
=========================================

Name: serial_word_comparator

Overview:
- Front-end stage that feeds the 6-bit equality comparator datapath.
- Receives two operand words A and B serially, one bit pair per accepted beat, LSB first. Assembles each word in a shift register.
- Once a full word pair is captured, registers the per-bit XNOR mask and an all-equal flag. Holds them on a valid/ready output handshake until consumed.

Parameters:
- WIDTH, 6, operand word width in bits (≥2); also the number of beats per frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream bit pair valid.
- in_ready  output  1  block can accept a bit pair.
- in_a  input  1  serial bit of operand A.
- in_b  input  1  serial bit of operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_a  output  WIDTH  captured word A.
- out_b  output  WIDTH  captured word B.
- out_mask  output  WIDTH  bitwise XNOR of A and B (1 = bit equal).
- out_equal  output  1  1 when out_mask is all ones.
- out_gt  output  1  unsigned A > B (feature-dependent).
- out_lt  output  1  unsigned A < B (feature-dependent).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low, on rst_n. All state is reset asynchronously.
- Reset values: every output register is 0 (in_ready, out_valid, out_a, out_b, out_mask, out_equal, out_gt, out_lt). The bit counter is 0 and the state is COLLECT.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- Beat accept: a beat is accepted on a clk edge with in_valid && in_ready.
- Bit placement: the k-th accepted beat of a frame (k = 0..WIDTH-1) writes in_a into bit k of the A shift register and in_b into bit k of the B shift register (LSB first).
- Counter: cnt has width $clog2(WIDTH). It increments per accepted beat and never wraps past WIDTH-1 within a frame.
- State COLLECT:
  - in_ready = 1, out_valid = 0.
  - On an accepted beat with cnt == WIDTH-1:
    - out_a and out_b load the completed words, including the current bit.
    - out_mask loads ~(A ^ B); out_equal loads &mask.
    - out_valid and in_ready are set to 1 and 0 at the same edge.
    - cnt clears; next state is HOLD.
- Latency: out_valid is high in the cycle after the last beat is accepted.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - All out_* data are stable until the handshake completes.
  - On out_valid && out_ready: out_valid goes 0 and in_ready goes 1 next cycle; next state is COLLECT.
  - Data outputs keep their last values after the handshake; they are don't-care when out_valid is 0.
- Throughput: at most one frame per WIDTH+1 cycles. There is no overlap between HOLD and COLLECT.
- Gaps: in_valid deassertion mid-frame stalls capture. cnt and partial words hold their values. There is no timeout.
- in_valid in HOLD: ignored, because in_ready is 0. Upstream must hold its beat until in_ready returns.
- Reset mid-frame or in HOLD: the partial frame is discarded, and all outputs and cnt return to reset values immediately.
- Register usage: no combinational path from in_* to out_*. The only combinational logic is mask/flag generation ahead of the output registers.

Optional Feature:
- Macro: CMP_MAGNITUDE_EN.
- Defined: at frame completion, out_gt loads (A > B) and out_lt loads (A < B), both unsigned and registered alongside out_equal. Exactly one of out_gt, out_lt, out_equal is 1 while out_valid is high.
- Undefined: the out_gt and out_lt ports remain and are tied to constant 0. No magnitude logic is synthesized.

Decomposition:
- Shared package cmp_pkg:
  - Parameter CMP_WIDTH = 6.
  - State enum cmp_state_t {COLLECT, HOLD}.
  - Function xnor_mask(a, b), returning ~(a ^ b).
- Sub-module: serial_shift_capture. It holds a WIDTH-bit register with a bit-indexed write and is instantiated twice, for A and B. All control stays in the top module.

Test Plan:
- Equal words: stream A = 100111 and B = 100111, LSB first, on 6 back-to-back beats, out_ready = 1. Expect out_valid on the 7th cycle with out_mask = 111111, out_equal = 1, out_a = out_b = 100111.
- Distinct words: stream C = 101010 and D = 010101. Expect out_mask = 000000, out_equal = 0; with CMP_MAGNITUDE_EN, out_gt = 1 and out_lt = 0.
- Backpressure: after a frame completes, hold out_ready = 0 for 3 cycles. Expect out_valid = 1, in_ready = 0 and outputs stable throughout, and in_ready = 1 the cycle after out_ready rises.
- Gapped input: insert in_valid = 0 gaps of 2 cycles between beats 2/3 and 4/5, with A = 000101 and B = 000011. Expect a correct result, out_mask = 111001 and out_equal = 0; with the macro, out_gt = 1.
- Mid-frame reset: accept 3 beats, then pulse rst_n low. Expect all outputs 0 immediately. A following full frame of A = B = 111111 then gives out_equal = 1 with no leftover bits.

Source files
------------

// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the serial word comparator front-end.
//   CMP_WIDTH   : default operand width (bits per word, beats per frame)
//   cmp_state_t : control state (COLLECT while assembling, HOLD while
//                 presenting a result)
//   xnor_mask   : per-bit equality mask, 1 where the operand bits match
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam int CMP_WIDTH = 6;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } cmp_state_t;

    function automatic logic [CMP_WIDTH-1:0] xnor_mask(
        input logic [CMP_WIDTH-1:0] a,
        input logic [CMP_WIDTH-1:0] b
    );
        return ~(a ^ b);
    endfunction

endpackage : cmp_pkg

// File: rtl/serial_shift_capture.sv
// -----------------------------------------------------------------------------
// serial_shift_capture
// WIDTH-bit capture register written one bit at a time at an explicit index.
// The word including the bit being written this cycle is exposed on
// word_next so the owner can register the completed word on the same edge
// as the final write.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (clears the word)
//   wr_en     in   write wr_bit into position wr_idx this cycle
//   wr_idx    in   bit position to write
//   wr_bit    in   bit value to write
//   word_next out  stored word with the pending write applied
// -----------------------------------------------------------------------------
module serial_shift_capture
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bit,
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-1:0] word_r;
    logic [WIDTH-1:0] word_next_s;

    // Overlay the pending bit write on the stored word.
    always_comb begin
        word_next_s = word_r;
        if (wr_en) begin
            word_next_s[wr_idx] = wr_bit;
        end else begin
            word_next_s = word_r;
        end
    end

    // Storage for the partially assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= '0;
        end else begin
            word_r <= word_next_s;
        end
    end

    assign word_next = word_next_s;

endmodule : serial_shift_capture

// File: rtl/serial_word_comparator.sv
// -----------------------------------------------------------------------------
// serial_word_comparator
// Assembles two operand words from a serial bit-pair stream (LSB first, one
// pair per accepted beat), then registers the words, their per-bit XNOR mask
// and an all-equal flag, held on a valid/ready handshake until consumed.
// Optional magnitude compare is enabled by defining CMP_MAGNITUDE_EN; without
// it out_gt/out_lt are constant 0.
// Ports:
//   clk, rst_n          clock (rising) and asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_ready registered
//   in_a, in_b          serial operand bits
//   out_valid/out_ready downstream handshake
//   out_a, out_b        captured words
//   out_mask            ~(A ^ B), 1 where bits are equal
//   out_equal           out_mask all ones
//   out_gt, out_lt      unsigned A > B / A < B (magnitude build only)
// -----------------------------------------------------------------------------
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_mask,
    output logic             out_equal,
    output logic             out_gt,
    output logic             out_lt
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cmp_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_a_r;
    logic [WIDTH-1:0] out_b_r;
    logic [WIDTH-1:0] out_mask_r;
    logic             out_equal_r;

    logic             beat_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] mask_s;

    // in_ready_r is only ever high in COLLECT, so it alone qualifies a beat.
    assign beat_s = in_valid & in_ready_r;

    serial_shift_capture #(.WIDTH(WIDTH), .IDX_W(CNT_W)) u_cap_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (beat_s),
        .wr_idx    (cnt_r),
        .wr_bit    (in_a),
        .word_next (a_next_s)
    );

    serial_shift_capture #(.WIDTH(WIDTH), .IDX_W(CNT_W)) u_cap_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (beat_s),
        .wr_idx    (cnt_r),
        .wr_bit    (in_b),
        .word_next (b_next_s)
    );

    // The shared helper is fixed at CMP_WIDTH; other widths use the same
    // expression inline.
    generate
        if (WIDTH == CMP_WIDTH) begin : g_mask_pkg
            assign mask_s = xnor_mask(a_next_s, b_next_s);
        end else begin : g_mask_inline
            assign mask_s = ~(a_next_s ^ b_next_s);
        end
    endgenerate

    // Frame control: beat counting, result capture and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= COLLECT;
            cnt_r       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_a_r     <= '0;
            out_b_r     <= '0;
            out_mask_r  <= '0;
            out_equal_r <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    if (beat_s) begin
                        if (cnt_r == CNT_LAST) begin
                            out_a_r     <= a_next_s;
                            out_b_r     <= b_next_s;
                            out_mask_r  <= mask_s;
                            out_equal_r <= &mask_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            cnt_r       <= '0;
                            state_r     <= HOLD;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= COLLECT;
                    end else begin
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= COLLECT;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMP_MAGNITUDE_EN
    logic out_gt_r;
    logic out_lt_r;

    // Magnitude flags, captured on the same edge as out_equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gt_r <= 1'b0;
            out_lt_r <= 1'b0;
        end else if (state_r == COLLECT && beat_s && cnt_r == CNT_LAST) begin
            out_gt_r <= (a_next_s > b_next_s);
            out_lt_r <= (a_next_s < b_next_s);
        end else begin
            out_gt_r <= out_gt_r;
            out_lt_r <= out_lt_r;
        end
    end

    assign out_gt = out_gt_r;
    assign out_lt = out_lt_r;
`else
    assign out_gt = 1'b0;
    assign out_lt = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_mask  = out_mask_r;
    assign out_equal = out_equal_r;

endmodule : serial_word_comparator

// File: tb/tb_serial_word_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_word_comparator
// Directed bench for serial_word_comparator (WIDTH = 6). Inputs change on the
// falling edge, outputs are sampled on the falling edge. Magnitude
// expectations follow CMP_MAGNITUDE_EN.
// -----------------------------------------------------------------------------
module tb_serial_word_comparator;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_a;
    logic         in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic [W-1:0] out_mask;
    logic         out_equal;
    logic         out_gt;
    logic         out_lt;

    int checks = 0;
    int errors = 0;

    serial_word_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_mask  (out_mask),
        .out_equal (out_equal),
        .out_gt    (out_gt),
        .out_lt    (out_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat at the falling edge and let the next rising edge take
    // it; waits (bounded) for in_ready. last_beat checks no early result.
    task automatic drive_beat(input logic a, input logic b, input logic last_beat);
        int waited;
        @(negedge clk);
        if (last_beat) check("no_early_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Stream a full frame LSB first; optional 2-cycle gaps after beats 2 and 4.
    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic gapped);
        for (int k = 0; k < W; k++) begin
            drive_beat(a[k], b[k], (k == W - 1));
            if (gapped && (k == 1 || k == 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("gap_in_ready", 32'(in_ready), 32'd1);
                check("gap_out_valid", 32'(out_valid), 32'd0);
                @(posedge clk);
            end
        end
    endtask

    // Check the result held just after a frame completes (at the falling edge).
    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] mask, input logic eq, input logic gt, input logic lt);
        logic exp_gt;
        logic exp_lt;
`ifdef CMP_MAGNITUDE_EN
        exp_gt = gt;
        exp_lt = lt;
`else
        exp_gt = 1'b0;
        exp_lt = 1'b0;
        if (gt || lt) exp_gt = 1'b0;
`endif
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_a"}, 32'(out_a), 32'(a));
        check({tag, "_b"}, 32'(out_b), 32'(b));
        check({tag, "_mask"}, 32'(out_mask), 32'(mask));
        check({tag, "_equal"}, 32'(out_equal), 32'(eq));
        check({tag, "_gt"}, 32'(out_gt), 32'(exp_gt));
        check({tag, "_lt"}, 32'(out_lt), 32'(exp_lt));
    endtask

    initial begin
        logic [W-1:0] hold_a;
        logic [W-1:0] hold_mask;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_mask", 32'(out_mask), 32'd0);
        check("rst_out_equal", 32'(out_equal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Equal words, back-to-back beats.
        send_frame(6'b100111, 6'b100111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("eq", 6'b100111, 6'b100111, 6'b111111, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("eq_consumed_valid", 32'(out_valid), 32'd0);
        check("eq_consumed_ready", 32'(in_ready), 32'd1);

        // Distinct words with 3 cycles of backpressure.
        out_ready = 1'b0;
        send_frame(6'b101010, 6'b010101, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        check_result("dist", 6'b101010, 6'b010101, 6'b000000, 1'b0, 1'b1, 1'b0);
        hold_a    = out_a;
        hold_mask = out_mask;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_a_stable", 32'(out_a), 32'(hold_a));
            check("bp_mask_stable", 32'(out_mask), 32'(hold_mask));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Gapped input.
        send_frame(6'b000101, 6'b000011, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("gap", 6'b000101, 6'b000011, 6'b111001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("gap_consumed_ready", 32'(in_ready), 32'd1);

        // Mid-frame reset after 3 beats.
        drive_beat(1'b1, 1'b0, 1'b0);
        drive_beat(1'b0, 1'b1, 1'b0);
        drive_beat(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_a", 32'(out_a), 32'd0);
        check("mrst_out_b", 32'(out_b), 32'd0);
        check("mrst_out_mask", 32'(out_mask), 32'd0);
        check("mrst_out_equal", 32'(out_equal), 32'd0);
        check("mrst_out_gt", 32'(out_gt), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_ready_back", 32'(in_ready), 32'd1);
        send_frame(6'b111111, 6'b111111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("after_rst", 6'b111111, 6'b111111, 6'b111111, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_word_comparator
